// File: rtl/i2s_stream_pkg.sv
// Shared constants, header packing and FSM state type for the I2S row streamer.
package i2s_stream_pkg;

  localparam int HEADER_BITS = 16;
  localparam int WORD_BITS   = 16;
  localparam int NX_W        = 4;
  localparam int NY_W        = 4;
  localparam int PAD_W       = 2;
  localparam int ROW_W       = 6;
  localparam int CNT_W       = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_TAIL
  } state_t;

  function automatic logic [HEADER_BITS-1:0] pack_header(
    input logic [NX_W-1:0]  nx,
    input logic [NY_W-1:0]  ny,
    input logic [ROW_W-1:0] row
  );
    return {nx, ny, {PAD_W{1'b0}}, row};
  endfunction

  // Payload words per frame: (nx+1)*(ny+1), 1..256.
  function automatic logic [CNT_W-1:0] word_total(
    input logic [NX_W-1:0] nx,
    input logic [NY_W-1:0] ny
  );
    return (CNT_W'(nx) + CNT_W'(1)) * (CNT_W'(ny) + CNT_W'(1));
  endfunction

endpackage

// File: rtl/i2s_word_shifter.sv
// MSB-first parallel-load shift register; bit_out is the bit currently on the line.
module i2s_word_shifter
  import i2s_stream_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] load_data,
  input  logic                 shift,
  output logic                 bit_out,
  output logic                 last_bit
);

  localparam int CW = $clog2(WORD_BITS);

  logic [WORD_BITS-1:0] sr;
  logic [CW-1:0]        idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= load_data;
      idx <= '0;
    end else if (shift) begin
      sr  <= {sr[WORD_BITS-2:0], 1'b0};
      idx <= idx + CW'(1);
    end
  end

  assign bit_out  = sr[WORD_BITS-1];
  assign last_bit = (idx == CW'(WORD_BITS - 1));

endmodule

// File: rtl/i2s_row_streamer.sv
// Serializes a header plus (nx+1)*(ny+1) payload words onto the shared I2S line, one row per frame.
module i2s_row_streamer
  import i2s_stream_pkg::*;
#(
  parameter int NUM_ROWS    = 8,
  parameter int TAIL_CYCLES = 2
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NX_W-1:0]      num_modules_x,
  input  logic [NY_W-1:0]      num_modules_y,
  input  logic [WORD_BITS-1:0] word_data,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic                 i2s_data,
  output logic                 i2s_clk_en,
  output logic [ROW_W-1:0]     row_num,
  output logic                 busy,
  output logic                 done
);

  localparam int              TW        = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;
  localparam logic [TW-1:0]   TAIL_LAST = TW'(TAIL_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     total_q, total_n, accepted_q, accepted_n;
  logic                 hold_full, hold_full_n;
  logic [WORD_BITS-1:0] hold_data;
  logic [TW-1:0]        tail_q, tail_n;
  logic                 clk_en_n, ready_n, done_n;
  logic                 xfer, more, avail, hold_take, hold_fill, start_acc, row_inc;
  logic                 sh_load, sh_shift, sh_last;
  logic [WORD_BITS-1:0] sh_data;

  i2s_word_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_data (sh_data),
    .shift     (sh_shift),
    .bit_out   (i2s_data),
    .last_bit  (sh_last)
  );

  assign xfer  = word_valid && word_ready;
  // Words still owed to the line: one parked in the holding register or not yet accepted.
  assign more  = hold_full || (accepted_q < total_q);
  assign avail = hold_full || xfer;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_n   = state;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_data   = hold_full ? hold_data : word_data;
    clk_en_n  = 1'b0;
    tail_n    = tail_q;
    hold_take = 1'b0;
    start_acc = 1'b0;
    row_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          sh_load   = 1'b1;
          sh_data   = pack_header(num_modules_x, num_modules_y, row_num);
          clk_en_n  = 1'b1;
          state_n   = ST_HEADER;
        end
      end
      ST_HEADER, ST_PAYLOAD: begin
        if (i2s_clk_en && !sh_last) begin
          sh_shift = 1'b1;
          clk_en_n = 1'b1;
        end else if (more) begin
          // Without a word ready the line stalls with the shifter frozen on its last bit.
          if (avail) begin
            sh_load   = 1'b1;
            hold_take = hold_full;
            clk_en_n  = 1'b1;
            state_n   = ST_PAYLOAD;
          end
        end else begin
          sh_shift = 1'b1;
          tail_n   = '0;
          state_n  = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (tail_q == TAIL_LAST) begin
          row_inc = 1'b1;
          state_n = ST_IDLE;
        end else begin
          tail_n = tail_q + TW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign hold_fill   = xfer && !sh_load;
  assign hold_full_n = hold_fill || (hold_full && !hold_take);
  assign total_n     = start_acc ? word_total(num_modules_x, num_modules_y) : total_q;
  assign accepted_n  = start_acc ? '0 : accepted_q + CNT_W'(xfer);
  assign ready_n     = !hold_full_n && (accepted_n < total_n) &&
                       ((state_n == ST_HEADER) || (state_n == ST_PAYLOAD));
  assign done_n      = (state_n == ST_TAIL) && (tail_n == TAIL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      total_q    <= '0;
      accepted_q <= '0;
      hold_full  <= 1'b0;
      // NOTE: hold_data is reset only for a deterministic power-up; hold_full alone qualifies it.
      hold_data  <= '0;
      tail_q     <= '0;
      i2s_clk_en <= 1'b0;
      word_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      row_num    <= '0;
    end else begin
      state      <= state_n;
      total_q    <= total_n;
      accepted_q <= accepted_n;
      hold_full  <= hold_full_n;
      if (hold_fill) hold_data <= word_data;
      tail_q     <= tail_n;
      i2s_clk_en <= clk_en_n;
      word_ready <= ready_n;
      busy       <= (state_n != ST_IDLE);
      done       <= done_n;
      if (row_inc) row_num <= (row_num == ROW_LAST) ? '0 : row_num + ROW_W'(1);
    end
  end

endmodule
